reg_file: RTL and testbench
===========================

// Module: reg_file
//
// PURPOSE
// - General-purpose register file for the 8-bit CPU datapath.
// - Two combinational read ports feed the ALU operands.
// - One clocked write port stores the ALU result.
// - A dedicated output mirrors one register (R15) as the CPU's visible result.
//
// PARAMETERS
// - DATA_W   8   width of each register and of every data port
// - ADDR_W   4   register address width; depth = 2**ADDR_W = 16 registers
// - OUT_REG  15  index of the register driven continuously onto cpu_out
//
// PORTS
// - clk           in   1       clock; all state changes on rising edge
// - reset         in   1       synchronous, active-high reset
// - RA1           in   ADDR_W  read address, port 1
// - RA2           in   ADDR_W  read address, port 2
// - WA            in   ADDR_W  write address
// - ALUResult     in   DATA_W  write data
// - write_enable  in   1       write strobe, sampled at clk rising edge
// - RD1           out  DATA_W  data at RA1
// - RD2           out  DATA_W  data at RA2
// - cpu_out       out  DATA_W  data in register OUT_REG
// - Declaration order: RA1, RA2, WA, ALUResult, clk, write_enable, RD1, RD2,
//   cpu_out, reset. reset is last so existing 9-port positional hookups bind unchanged.
//
// BEHAVIOUR
// - Storage: 16 x 8-bit registers R0..R15. R0 is an ordinary register (not hardwired).
// - Reset:
//   - At a rising edge with reset=1, all 16 registers clear to 0.
//   - Hence RD1 = RD2 = cpu_out = 0 after reset.
//   - reset has priority over write_enable; a same-edge write is dropped.
// - Write:
//   - At a rising edge with reset=0 and write_enable=1, R[WA] <= ALUResult.
//   - With write_enable=0, all registers hold.
//   - Exactly one register changes per write; latency 1 edge.
// - Read:
//   - Purely combinational, zero latency: RD1 = R[RA1], RD2 = R[RA2].
//   - Both ports may address the same register.
// - cpu_out: combinational copy of R[OUT_REG]; updates in the same cycle as its write edge.
// - Read-during-write, same address: read ports show the OLD value until the edge,
//   then the new value. No write-to-read bypass.
// - Out-of-range addresses cannot occur (full 4-bit decode). No X propagation
//   from stored state after the first reset.
// - Before the first reset, contents are undefined. The bench must reset before checking.
//
// TESTING
// - Reset 2 cycles -> RD1 = RD2 = cpu_out = 0 for every RA1/RA2 pair 0..15.
// - we=1, WA=10, ALUResult=8'h03, edge; then RA1=10 -> RD1=3. Other registers stay 0.
// - we=0, WA=12, ALUResult=8'h24, edge; then RA2=12 -> RD2=0 (write suppressed).
// - we=1, WA=15, ALUResult=8'hF1, edge -> cpu_out=8'hF1. RA1=15 -> RD1=8'hF1 in the same cycle.
// - RA1=RA2=WA=5, R5=8'h11, write 8'h22: before edge RD1=RD2=8'h11, after edge 8'h22.
// - reset=1 and we=1 with WA=3, ALUResult=8'hAA on the same edge -> R3=0, all registers 0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 16 x 8-bit general-purpose register file for the 8-bit CPU datapath.
//
// Two read ports feed the ALU operands with zero latency. One write port stores
// the ALU result on the rising clock edge. A third output continuously mirrors
// register OUT_REG as the CPU's visible result.
//
// Ports:
//   RA1, RA2      in   ADDR_W  read addresses, ports 1 and 2
//   WA            in   ADDR_W  write address
//   ALUResult     in   DATA_W  write data
//   clk           in   1       clock; all state changes on the rising edge
//   write_enable  in   1       write strobe, sampled at the rising edge
//   RD1, RD2      out  DATA_W  R[RA1], R[RA2] (combinational)
//   cpu_out       out  DATA_W  R[OUT_REG] (combinational)
//   reset         in   1       synchronous active-high reset; clears every register
//
// reset is last in the port list so that existing 9-port positional hookups still
// bind correctly.

module reg_file #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned OUT_REG = 15
) (
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              clk,
  input  logic              write_enable,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] cpu_out,
  input  logic              reset
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Packed so the whole array can be cleared with a single '0.
  logic [Depth-1:0][DATA_W-1:0] regs_q, regs_d;

  // Next state: only the addressed register changes, and only when strobed.
  // Reset is applied in the flop process so it overrides a same-edge write.
  always_comb begin
    regs_d = regs_q;
    if (write_enable) begin
      regs_d[WA] = ALUResult;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the stored state: no write-to-read bypass, so a
  // same-address read shows the old value until the write edge.
  always_comb begin
    RD1     = regs_q[RA1];
    RD2     = regs_q[RA2];
    cpu_out = regs_q[OUT_REG];
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1, RA2, WA;
  logic [7:0] ALUResult;
  logic       write_enable;
  logic [7:0] RD1, RD2, cpu_out;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .ALUResult    (ALUResult),
    .clk          (clk),
    .write_enable (write_enable),
    .RD1          (RD1),
    .RD2          (RD2),
    .cpu_out      (cpu_out),
    .reset        (reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then let outputs settle before anything is sampled.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Checks every register through both read ports against one expected image.
  task automatic chk_all(input string tag, input logic [7:0] exp [16]);
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      RA2 = 4'(15 - i);
      #1;
      chk($sformatf("%s_rd1_r%0d", tag, i), RD1, exp[i]);
      chk($sformatf("%s_rd2_r%0d", tag, 15 - i), RD2, exp[15 - i]);
    end
  endtask

  logic [7:0] img [16];

  initial begin
    reset = 1'b1;
    write_enable = 1'b0;
    RA1 = '0; RA2 = '0; WA = '0; ALUResult = '0;
    edge_step();
    edge_step();
    reset = 1'b0;
    #1;

    // After reset: every RA1/RA2 pair reads 0, cpu_out is 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        RA1 = 4'(a);
        RA2 = 4'(b);
        #1;
        chk("rst_rd1", RD1, 8'h00);
        chk("rst_rd2", RD2, 8'h00);
      end
    end
    chk("rst_cpu_out", cpu_out, 8'h00);
    for (int i = 0; i < 16; i++) img[i] = 8'h00;

    // Write R10 = 03; only R10 changes.
    write_enable = 1'b1; WA = 4'd10; ALUResult = 8'h03;
    edge_step();
    write_enable = 1'b0;
    RA1 = 4'd10;
    #1;
    chk("wr10_rd1", RD1, 8'h03);
    img[10] = 8'h03;
    chk_all("wr10", img);
    chk("wr10_cpu_out", cpu_out, 8'h00);

    // Suppressed write to R12.
    write_enable = 1'b0; WA = 4'd12; ALUResult = 8'h24;
    edge_step();
    RA2 = 4'd12;
    #1;
    chk("nowe_rd2", RD2, 8'h00);
    chk_all("nowe", img);

    // Write R15 = F1: visible on cpu_out and RD1.
    write_enable = 1'b1; WA = 4'd15; ALUResult = 8'hF1;
    edge_step();
    write_enable = 1'b0;
    chk("wr15_cpu_out", cpu_out, 8'hF1);
    RA1 = 4'd15;
    #1;
    chk("wr15_rd1", RD1, 8'hF1);
    img[15] = 8'hF1;
    chk_all("wr15", img);

    // R5 = 11, then same-address read during write of 22.
    write_enable = 1'b1; WA = 4'd5; ALUResult = 8'h11;
    edge_step();
    RA1 = 4'd5; RA2 = 4'd5; ALUResult = 8'h22;
    #1;
    chk("rdw_before_rd1", RD1, 8'h11);
    chk("rdw_before_rd2", RD2, 8'h11);
    #2;
    chk("rdw_before_late_rd1", RD1, 8'h11);
    edge_step();
    write_enable = 1'b0;
    chk("rdw_after_rd1", RD1, 8'h22);
    chk("rdw_after_rd2", RD2, 8'h22);
    img[5] = 8'h22;
    chk_all("rdw", img);

    // Reset wins over a same-edge write to R3.
    reset = 1'b1; write_enable = 1'b1; WA = 4'd3; ALUResult = 8'hAA;
    edge_step();
    reset = 1'b0; write_enable = 1'b0;
    RA1 = 4'd3;
    #1;
    chk("rstwe_r3", RD1, 8'h00);
    chk("rstwe_cpu_out", cpu_out, 8'h00);
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    chk_all("rstwe", img);

    // Write R0 (ordinary register) and confirm it holds across idle edges.
    write_enable = 1'b1; WA = 4'd0; ALUResult = 8'h5C;
    edge_step();
    write_enable = 1'b0; ALUResult = 8'h00;
    edge_step();
    edge_step();
    RA2 = 4'd0;
    #1;
    chk("r0_hold_rd2", RD2, 8'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
